// File: rtl/fifo_pkg.sv
// Shared buffer definitions: read-port mode constants, flag bundle and a
// ceiling-log2 helper used by the FIFO family and other buffer users.
package fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  function automatic int unsigned clog2(input int unsigned value);
    clog2 = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) clog2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/syn_fifo_pro_if.sv
// Handshake/status bundle of syn_fifo_pro. The master drives requests and
// flush; the slave (the FIFO) drives read data, flags and counters.
interface syn_fifo_pro_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  clr;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  is_empty;
  logic                  is_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   data_avail;
  logic [ADDR_WIDTH:0]   room_avail;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, w_en, w_data, r_en,
    input  r_data, r_valid, is_empty, is_full, almost_full, almost_empty,
           data_avail, room_avail, overflow, underflow
  );

  modport slave (
    input  clr, w_en, w_data, r_en,
    output r_data, r_valid, is_empty, is_full, almost_full, almost_empty,
           data_avail, room_avail, overflow, underflow
  );
endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with
// read enable (1-cycle latency). Read data holds while re_i is low.
module fifo_dpram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];

  // Write port and registered read port; same-address access returns old data.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/syn_fifo_pro.sv
// Synchronous FIFO with occupancy/room counters, programmable almost flags,
// sticky overflow/underflow and synchronous flush. Read port is either
// standard (registered, r_valid pulses one cycle after a pop) or FWFT.
module syn_fifo_pro
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input logic           clk,
  input logic           rst_n,
  syn_fifo_pro_if.slave bus
);

  localparam int unsigned FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int          PTR_W      = ADDR_WIDTH + 1;
  localparam bit          IS_FWFT    = (FWFT == int'(FIFO_MODE_FWFT));
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);
  localparam fifo_flags_t FLAGS_RST = '{empty: 1'b1, full: 1'b0,
                                        afull: (AF_LEVEL == 0), aempty: 1'b1};

  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W-1:0]      occ_q, occ_d, room_q, room_d, ram_cnt;
  fifo_flags_t           flags_q, flags_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, ram_dout;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  live, wr_acc, rd_acc, fetch, ram_re;

  // In FWFT mode the RAM's own read register is the output stage: rptr counts
  // words moved into it, valid_q marks it loaded, and occupancy includes it.
  // Next-state pointers, occupancy, flags and error bits.
  always_comb begin
    live    = rst_n & ~bus.clr;
    wr_acc  = live & bus.w_en & ~flags_q.full;
    rd_acc  = live & bus.r_en & (IS_FWFT ? valid_q : ~flags_q.empty);
    ram_cnt = wptr_q - rptr_q;
    fetch   = (ram_cnt != '0) & (~valid_q | rd_acc);
    ram_re  = live & (IS_FWFT ? fetch : rd_acc);

    wptr_d  = wptr_q + PTR_W'(wr_acc);
    rptr_d  = rptr_q + PTR_W'(ram_re);
    occ_d   = occ_q + PTR_W'(wr_acc) - PTR_W'(rd_acc);
    room_d  = DEPTH_C - occ_d;

    flags_d        = FLAGS_RST;
    flags_d.empty  = (occ_d == '0);
    flags_d.full   = (occ_d == DEPTH_C);
    flags_d.afull  = (occ_d >= AF_C);
    flags_d.aempty = (occ_d <= AE_C);

    valid_d = IS_FWFT ? (ram_re | (valid_q & ~rd_acc)) : rd_acc;
    hold_d  = valid_q ? ram_dout : hold_q;
    ovf_d   = ovf_q | (bus.w_en & flags_q.full);
    unf_d   = unf_q | (bus.r_en & (IS_FWFT ? ~valid_q : flags_q.empty));
  end

  // State registers; reset and flush share the same effect.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      room_q  <= DEPTH_C;
      flags_q <= FLAGS_RST;
      valid_q <= 1'b0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      room_q  <= room_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (bus.w_data),
    .re_i    (ram_re),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_dout)
  );

  // hold_q keeps the last presented word (zero after flush) while no word is valid.
  assign bus.r_data       = valid_q ? ram_dout : hold_q;
  assign bus.r_valid      = valid_q;
  assign bus.is_empty     = flags_q.empty;
  assign bus.is_full      = flags_q.full;
  assign bus.almost_full  = flags_q.afull;
  assign bus.almost_empty = flags_q.aempty;
  assign bus.data_avail   = occ_q;
  assign bus.room_avail   = room_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
